// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder: one-hot state codes, the
// event bundle and the timer width helper.
package key_event_pkg;

  localparam int NUM_STATES = 5;

  typedef logic [NUM_STATES-1:0] state_t;

  localparam state_t ST_IDLE      = 5'b00001;
  localparam state_t ST_PRESS1    = 5'b00010;
  localparam state_t ST_LONG_HELD = 5'b00100;
  localparam state_t ST_WAIT2     = 5'b01000;
  localparam state_t ST_PRESS2    = 5'b10000;

  typedef struct packed {
    logic click;
    logic dbl;
    logic lng;
    logic rpt;
  } events_t;

  // Width of the shared timer: wide enough for the longest of the three windows.
  function automatic int timer_width(input int long_c, input int dclick_c, input int repeat_c);
    int m;
    m = long_c;
    if (dclick_c > m) m = dclick_c;
    if (repeat_c > m) m = repeat_c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_event_if.sv
// Debouncer-to-decoder link: strobe/level in, one-cycle event pulses out.
// master = key source / consumer side, slave = key_event_decoder.
interface key_event_if;

  logic key_flag;
  logic key_state;
  logic evt_click;
  logic evt_double;
  logic evt_long;
  logic evt_repeat;
  logic pressed;

  modport master (
    output key_flag, key_state,
    input  evt_click, evt_double, evt_long, evt_repeat, pressed
  );

  modport slave (
    input  key_flag, key_state,
    output evt_click, evt_double, evt_long, evt_repeat, pressed
  );

endinterface

// File: rtl/key_event_timer.sv
// Saturating clear/enable counter with a registered compare against a runtime
// limit; hit is high in the cycle the count equals the limit it was armed with.
module key_event_timer
  import key_event_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             hit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Comparing the next count lets hit line up with the cycle the count holds the limit.
  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      hit     <= 1'b0;
    end else begin
      count_q <= count_d;
      hit     <= (count_d == limit);
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key strobes into click / double / long / repeat pulses.
// Optional auto-repeat while a long press is held: define KEY_EVENT_REPEAT_EN.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 15_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  key_event_if.slave  bus
);

  localparam int TW = timer_width(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES);

  localparam logic [TW-1:0] LONG_LIM   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DCLICK_LIM = TW'(DCLICK_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_LIM = TW'(REPEAT_CYCLES - 1);
`endif

  logic          press_ev;
  logic          release_ev;
  state_t        state_q;
  state_t        state_d;
  events_t       evt_q;
  events_t       evt_d;
  logic          pressed_q;
  logic          rearm;
  logic          timer_clear;
  logic          timer_hit;
  logic [TW-1:0] timer_limit;

  assign press_ev   = bus.key_flag & ~bus.key_state;
  assign release_ev = bus.key_flag &  bus.key_state;

  // Input events are tested before timer expiry so a coincident strobe wins.
  always_comb begin
    state_d = state_q;
    evt_d   = '0;
    rearm   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_ev) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (release_ev) begin
          state_d = ST_WAIT2;
        end else if (timer_hit) begin
          evt_d.lng = 1'b1;
          state_d   = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (release_ev) begin
          state_d = ST_IDLE;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (timer_hit) begin
          evt_d.rpt = 1'b1;
          rearm     = 1'b1;
        end
`endif
      end
      ST_WAIT2: begin
        if (press_ev) begin
          evt_d.dbl = 1'b1;
          state_d   = ST_PRESS2;
        end else if (timer_hit) begin
          evt_d.click = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (release_ev) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign timer_clear = (state_d != state_q) | rearm;

  // The limit follows the state being entered, since hit is registered from the next count.
  always_comb begin
    timer_limit = '1;
    case (state_d)
      ST_PRESS1:    timer_limit = LONG_LIM;
      ST_WAIT2:     timer_limit = DCLICK_LIM;
`ifdef KEY_EVENT_REPEAT_EN
      ST_LONG_HELD: timer_limit = REPEAT_LIM;
`endif
      default:      timer_limit = '1;
    endcase
  end

  key_event_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (1'b1),
    .limit  (timer_limit),
    .hit    (timer_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      evt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      evt_q     <= evt_d;
      pressed_q <= (state_d == ST_PRESS1) | (state_d == ST_LONG_HELD) | (state_d == ST_PRESS2);
    end
  end

  assign bus.evt_click  = evt_q.click;
  assign bus.evt_double = evt_q.dbl;
  assign bus.evt_long   = evt_q.lng;
  assign bus.evt_repeat = evt_q.rpt;  // never set without KEY_EVENT_REPEAT_EN, so constant 0
  assign bus.pressed    = pressed_q;

`ifndef SYNTHESIS
  a_evt_exclusive: assert property (@(posedge clk) disable iff (reset)
    $onehot0({bus.evt_click, bus.evt_double, bus.evt_long, bus.evt_repeat}));
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed bench for key_event_decoder against a timestamp-based
// model of the gesture rules (LONG=20, DCLICK=10, REPEAT=5).
module tb_key_event_decoder;

  localparam int LC = 20;
  localparam int DC = 10;
  localparam int RC = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  key_event_if bus ();

  key_event_decoder #(
    .LONG_CYCLES   (LC),
    .DCLICK_CYCLES (DC),
    .REPEAT_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Gesture model: held level, presses in current gesture, timing origin, long-press time.
  bit m_held;
  int m_presses;
  int m_start;
  int m_long_at;

  int n_click, n_double, n_long, n_repeat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.evt_click, bus.evt_double, bus.evt_long, bus.evt_repeat, bus.pressed};
  endfunction

  task automatic model_reset();
    m_held    = 1'b0;
    m_presses = 0;
    m_start   = 0;
    m_long_at = -1;
  endtask

  // Expected outputs for the cycle after cycle `cyc`, given this cycle's strobe.
  task automatic model_step(input bit pr, input bit rl, output logic [4:0] e);
    int nxt;
    nxt = cyc + 1;
    e   = '0;
    if (!m_held) begin
      if (pr) begin
        m_held    = 1'b1;
        m_long_at = -1;
        m_start   = nxt;
        if (m_presses == 1) begin
          e[3]      = 1'b1;
          m_presses = 2;
        end else begin
          m_presses = 1;
        end
      end else if (m_presses == 1 && nxt == m_start + DC) begin
        e[4]      = 1'b1;
        m_presses = 0;
      end
    end else begin
      if (rl) begin
        m_held = 1'b0;
        if (m_presses == 1 && m_long_at < 0) m_start = nxt;
        else m_presses = 0;
        m_long_at = -1;
      end else if (m_presses == 1 && m_long_at < 0 && nxt == m_start + LC) begin
        e[2]      = 1'b1;
        m_long_at = nxt;
      end
`ifdef KEY_EVENT_REPEAT_EN
      else if (m_long_at >= 0 && ((nxt - m_long_at) % RC) == 0) begin
        e[1] = 1'b1;
      end
`endif
    end
    e[0] = m_held;
  endtask

  task automatic tick(input logic f, input logic s);
    logic [4:0] exp_v;
    bus.key_flag  = f;
    bus.key_state = s;
    model_step(f && !s, f && s, exp_v);
    @(posedge clk);
    #1;
    check("outputs", 32'(outs()), 32'(exp_v));
    n_click  += int'(bus.evt_click);
    n_double += int'(bus.evt_double);
    n_long   += int'(bus.evt_long);
    n_repeat += int'(bus.evt_repeat);
    cyc++;
    bus.key_flag = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b1);
  endtask

  task automatic press();
    tick(1'b1, 1'b0);
  endtask

  task automatic release_key();
    tick(1'b1, 1'b1);
  endtask

  task automatic clear_counts();
    n_click = 0; n_double = 0; n_long = 0; n_repeat = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_async", 32'(outs()), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_hold", 32'(outs()), 32'd0);
    reset = 1'b0;
    cyc++;
  endtask

  initial begin
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(outs()), 32'd0);
    reset = 1'b0;

    // Single click
    clear_counts();
    press(); idle(4); release_key(); idle(DC + 5);
    check("click_count", 32'(n_click), 32'd1);
    check("click_others", 32'(n_double + n_long + n_repeat), 32'd0);

    // Double click, then silent release
    clear_counts();
    press(); idle(2); release_key(); idle(3); press(); idle(3); release_key(); idle(DC + 5);
    check("dbl_count", 32'(n_double), 32'd1);
    check("dbl_no_click", 32'(n_click), 32'd0);

    // Long hold of 40 cycles
    clear_counts();
    press(); idle(39); release_key(); idle(12);
    check("long_count", 32'(n_long), 32'd1);
`ifdef KEY_EVENT_REPEAT_EN
    check("repeat_count", 32'(n_repeat), 32'd3);
`else
    check("repeat_count", 32'(n_repeat), 32'd0);
`endif

    // Release coincident with long expiry
    clear_counts();
    press(); idle(LC - 1); release_key(); idle(DC + 5);
    check("tie_no_long", 32'(n_long), 32'd0);
    check("tie_click", 32'(n_click), 32'd1);

    // Second press coincident with click expiry
    clear_counts();
    press(); idle(3); release_key(); idle(DC - 1); press(); idle(2); release_key(); idle(DC + 5);
    check("tie_double", 32'(n_double), 32'd1);
    check("tie_no_click", 32'(n_click), 32'd0);

    // Duplicate strobes and idle release
    clear_counts();
    release_key(); press(); press(); idle(2); press(); release_key(); release_key(); idle(DC + 5);
    check("dup_click", 32'(n_click), 32'd1);
    check("dup_double", 32'(n_double), 32'd0);

    // Reset in WAIT2 and in PRESS1, then a fresh click
    clear_counts();
    press(); idle(2); release_key(); idle(3); do_reset(); idle(DC + 5);
    press(); idle(5); do_reset(); idle(LC + 5);
    check("rst_silent", 32'(n_click + n_double + n_long + n_repeat), 32'd0);
    press(); idle(3); release_key(); idle(DC + 5);
    check("rst_fresh_click", 32'(n_click), 32'd1);

    // Random gestures around the thresholds
    for (int g = 0; g < 200; g++) begin
      int r;
      r = int'($urandom_range(0, 11));
      press();
      idle(int'($urandom_range(0, 45)));
      if (r == 0) begin
        do_reset();
      end else begin
        if (r == 1) press();
        release_key();
      end
      if (r == 2) release_key();
      idle(int'($urandom_range(0, 14)));
    end
    idle(LC + DC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
